rx_symbol_fifo: RTL and testbench
=================================

RX_SYMBOL_FIFO -- requirements
Module: rx_symbol_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, symbol width.
REQ-002 SHALL have parameter SYMBOL_COUNT_WIDTH, default 4, symbol-in-block index width (16 symbols/block).
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, FIFO depth 2^ADDR_WIDTH entries.
REQ-004 SHALL have parameter MAX_DROP, default 4, maximum SKP symbols dropped per SKP ordered set.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 rx_clk  input  1  rising-edge clock.
REQ-007 rx_rst  input  1  asynchronous active-high reset.
REQ-008 Soft_RST_blocks  input  1  synchronous clear, same effect as reset.
REQ-009 wr_en  input  1  symbol valid from block alignment (elstc_buff_en).
REQ-010 rx_data  input  DATA_WIDTH  received symbol.
REQ-011 block_type  input  1  1 = ordered-set block, 0 = data block.
REQ-012 symbols_count  input  SYMBOL_COUNT_WIDTH  index of rx_data within its block.
REQ-013 skp_drop_en  input  1  enables SKP symbol deletion.
REQ-014 rd_en  input  1  downstream read request.
REQ-015 rd_data  output  DATA_WIDTH  read symbol.
REQ-016 rd_block_type  output  1  block_type of read symbol.
REQ-017 rd_sob  output  1  read symbol had symbols_count == 0.
REQ-018 rd_valid  output  1  rd_data/rd_block_type/rd_sob valid this cycle.
REQ-019 empty, full  output  1 each  FIFO status.
REQ-020 occupancy  output  ADDR_WIDTH+1  entries stored.
REQ-021 overflow  output  1  sticky, write lost.
REQ-022 skp_dropped  output  1  one-cycle pulse per dropped SKP symbol.

Function
REQ-023 Entries SHALL store {block_type, sob, rx_data}; read/write pointers ADDR_WIDTH+1 bits, wrap modulo 2^(ADDR_WIDTH+1); full = MSBs differ and low bits equal; empty = pointers equal.
REQ-024 A write SHALL occur when wr_en && !full && symbol not dropped.
REQ-025 When full, writes SHALL be refused even if rd_en is asserted in the same cycle.
REQ-026 A read SHALL occur when rd_en && !empty; rd_data, rd_block_type, rd_sob registered, rd_valid high the following cycle (latency 1), otherwise rd_valid low and data held.
REQ-027 When empty, a simultaneous write SHALL be stored; rd_en that cycle is ignored.
REQ-028 occupancy SHALL update each cycle by +1 write, -1 read, 0 for both or neither.
REQ-029 overflow SHALL be set when wr_en && full && symbol not dropped; cleared only by reset/Soft_RST_blocks.
REQ-030 SKP FSM states: NORMAL, SKP_BLK; reset state NORMAL.
REQ-031 NORMAL->SKP_BLK when wr_en, symbols_count == 0, block_type == 1, rx_data == 8'hAA; drop_cnt cleared to 0; symbol 0 is always written.
REQ-032 In SKP_BLK, a symbol with symbols_count != 0, rx_data == 8'hAA, skp_drop_en == 1 and drop_cnt < MAX_DROP SHALL be dropped (not written), drop_cnt incremented, skp_dropped pulsed.
REQ-033 In SKP_BLK, a symbol != 8'hAA (e.g. SKP_END 8'hE1) SHALL be written and the FSM SHALL return to NORMAL.
REQ-034 Any wr_en with symbols_count == 0 SHALL re-evaluate REQ-031 from either state (new block aborts SKP_BLK).
REQ-035 Dropped symbols SHALL never set overflow nor change occupancy.

Reset
REQ-036 On rx_rst (async) or Soft_RST_blocks (sync): pointers 0, occupancy 0, empty 1, full 0, overflow 0, rd_valid 0, rd_data 0, rd_block_type 0, rd_sob 0, skp_dropped 0, FSM NORMAL, drop_cnt 0.
REQ-037 Reset mid-operation SHALL discard all stored entries; no read completes in the reset cycle.

Verification
REQ-038 Write 16 data symbols 8'h00..8'h0F (block_type 0), no reads -> full=1, occupancy=16; 17th write -> overflow=1, occupancy 16.
REQ-039 Full FIFO, rd_en and wr_en same cycle -> read occurs, write refused, overflow=1, occupancy 15; next cycle rd_valid=1, rd_data=8'h00, rd_sob=1.
REQ-040 Empty FIFO, wr_en+rd_en same cycle with 8'h5A -> occupancy 1, rd_valid=0 next cycle; rd_en next -> rd_data=8'h5A.
REQ-041 SKP OS: block_type 1, symbols 0..7 = 8'hAA, symbol 8 = 8'hE1, skp_drop_en=1 -> symbols 1..4 dropped (4 pulses), 5 entries written (AA, AA, AA, AA, E1), occupancy 5.
REQ-042 Same SKP OS with skp_drop_en=0 -> all 9 symbols written, no skp_dropped pulse.
REQ-043 Assert rx_rst with occupancy 7 and overflow=1 -> all outputs to REQ-036 values immediately; writes resume normally after release.

Source files
------------

// File: rtl/rx_symbol_fifo_if.sv
// Symbol-side bus of the receive symbol FIFO: block-alignment write port,
// downstream read port and FIFO status.
interface rx_symbol_fifo_if #(
  parameter int DATA_WIDTH         = 8,
  parameter int SYMBOL_COUNT_WIDTH = 4,
  parameter int ADDR_WIDTH         = 4
) ();

  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         rx_data;
  logic                          block_type;
  logic [SYMBOL_COUNT_WIDTH-1:0] symbols_count;
  logic                          skp_drop_en;
  logic                          rd_en;

  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          rd_block_type;
  logic                          rd_sob;
  logic                          rd_valid;
  logic                          empty;
  logic                          full;
  logic [ADDR_WIDTH:0]           occupancy;
  logic                          overflow;
  logic                          skp_dropped;

  modport master (
    output wr_en, rx_data, block_type, symbols_count, skp_drop_en, rd_en,
    input  rd_data, rd_block_type, rd_sob, rd_valid, empty, full,
           occupancy, overflow, skp_dropped
  );

  modport slave (
    input  wr_en, rx_data, block_type, symbols_count, skp_drop_en, rd_en,
    output rd_data, rd_block_type, rd_sob, rd_valid, empty, full,
           occupancy, overflow, skp_dropped
  );

endinterface

// File: rtl/rx_symbol_fifo.sv
// Receive symbol FIFO with SKP ordered-set symbol deletion: stores
// {block_type, start-of-block, symbol} and registers the read side.
module rx_symbol_fifo #(
  parameter int DATA_WIDTH         = 8,
  parameter int SYMBOL_COUNT_WIDTH = 4,
  parameter int ADDR_WIDTH         = 4,
  parameter int MAX_DROP           = 4
) (
  input  logic              rx_clk,
  input  logic              rx_rst,
  input  logic              Soft_RST_blocks,
  rx_symbol_fifo_if.slave   bus
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int ENTRY_W = DATA_WIDTH + 2;
  localparam int PTR_W   = ADDR_WIDTH + 1;
  localparam int DROP_W  = $clog2(MAX_DROP + 1);

  localparam logic [DATA_WIDTH-1:0] SKP_SYM    = DATA_WIDTH'(8'hAA);
  localparam logic [DROP_W-1:0]     MAX_DROP_C = DROP_W'(MAX_DROP);

  typedef enum logic {
    NORMAL  = 1'b0,
    SKP_BLK = 1'b1
  } skp_state_e;

  logic [ENTRY_W-1:0]    mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  skp_state_e            state_q, state_d;
  logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_bt_q, rd_bt_d;
  logic                  rd_sob_q, rd_sob_d;
  logic                  skp_dropped_q, skp_dropped_d;

  logic                  is_skp;
  logic                  is_sob;
  logic                  full_w;
  logic                  empty_w;
  logic                  drop_sym;
  logic                  wr_do;
  logic                  rd_do;
  logic [ENTRY_W-1:0]    rd_entry;

  assign is_skp  = (bus.rx_data == SKP_SYM);
  assign is_sob  = (bus.symbols_count == '0);
  assign full_w  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign empty_w = (wr_ptr_q == rd_ptr_q);

  assign rd_entry = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  // SKP deletion FSM; symbol 0 of every block restarts the decision.
  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    drop_sym   = 1'b0;
    if (bus.wr_en) begin
      if (is_sob) begin
        drop_cnt_d = '0;
        state_d    = (bus.block_type && is_skp) ? SKP_BLK : NORMAL;
      end else if (state_q == SKP_BLK) begin
        if (!is_skp) begin
          state_d = NORMAL;
        end else if (bus.skp_drop_en && (drop_cnt_q < MAX_DROP_C)) begin
          drop_sym   = 1'b1;
          drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
      end
    end
    if (Soft_RST_blocks) begin
      state_d    = NORMAL;
      drop_cnt_d = '0;
    end
  end

  assign wr_do = bus.wr_en && !full_w && !drop_sym;
  assign rd_do = bus.rd_en && !empty_w;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    overflow_d    = overflow_q;
    rd_valid_d    = rd_do;
    rd_data_d     = rd_data_q;
    rd_bt_d       = rd_bt_q;
    rd_sob_d      = rd_sob_q;
    skp_dropped_d = drop_sym;
    if (wr_do) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_do) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rd_data_d = rd_entry[DATA_WIDTH-1:0];
      rd_sob_d  = rd_entry[DATA_WIDTH];
      rd_bt_d   = rd_entry[DATA_WIDTH+1];
    end
    // A write refused because the FIFO is full is lost; dropped SKPs are not.
    if (bus.wr_en && full_w && !drop_sym) begin
      overflow_d = 1'b1;
    end
    if (Soft_RST_blocks) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      overflow_d    = 1'b0;
      rd_valid_d    = 1'b0;
      rd_data_d     = '0;
      rd_bt_d       = 1'b0;
      rd_sob_d      = 1'b0;
      skp_dropped_d = 1'b0;
    end
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      state_q       <= NORMAL;
      drop_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_bt_q       <= 1'b0;
      rd_sob_q      <= 1'b0;
      skp_dropped_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      state_q       <= state_d;
      drop_cnt_q    <= drop_cnt_d;
      overflow_q    <= overflow_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      rd_bt_q       <= rd_bt_d;
      rd_sob_q      <= rd_sob_d;
      skp_dropped_q <= skp_dropped_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge rx_clk) begin
    if (wr_do && !Soft_RST_blocks && !rx_rst) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {bus.block_type, is_sob, bus.rx_data};
    end
  end

  assign bus.rd_data       = rd_data_q;
  assign bus.rd_block_type = rd_bt_q;
  assign bus.rd_sob        = rd_sob_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.empty         = empty_w;
  assign bus.full          = full_w;
  assign bus.occupancy     = wr_ptr_q - rd_ptr_q;
  assign bus.overflow      = overflow_q;
  assign bus.skp_dropped   = skp_dropped_q;

endmodule

// File: tb/tb_rx_symbol_fifo.sv
// Directed bench for rx_symbol_fifo with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_rx_symbol_fifo;

  localparam int DW    = 8;
  localparam int SCW   = 4;
  localparam int AW    = 4;
  localparam int MD    = 4;
  localparam int DEPTH = 1 << AW;

  logic rx_clk   = 1'b0;
  logic rx_rst   = 1'b1;
  logic soft_rst = 1'b0;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  rx_symbol_fifo_if #(.DATA_WIDTH(DW), .SYMBOL_COUNT_WIDTH(SCW), .ADDR_WIDTH(AW)) bus ();

  rx_symbol_fifo #(
    .DATA_WIDTH(DW), .SYMBOL_COUNT_WIDTH(SCW), .ADDR_WIDTH(AW), .MAX_DROP(MD)
  ) dut (
    .rx_clk          (rx_clk),
    .rx_rst          (rx_rst),
    .Soft_RST_blocks (soft_rst),
    .bus             (bus)
  );

  always #5 rx_clk = ~rx_clk;

  // Reference model: a queue of {block_type, sob, data} entries.
  logic [DW+1:0] mq[$];
  bit            m_in_skp  = 1'b0;
  int            m_drops   = 0;
  logic [DW-1:0] m_rd_data = '0;
  bit            m_rd_bt   = 1'b0;
  bit            m_rd_sob  = 1'b0;
  bit            m_rd_vld  = 1'b0;
  bit            m_ovf     = 1'b0;
  bit            m_skp     = 1'b0;

  always @(posedge rx_clk or posedge rx_rst) begin
    bit was_full, was_empty, drop, sob, aa;
    logic [DW+1:0] e;
    if (rx_rst || soft_rst) begin
      mq.delete();
      m_in_skp = 0; m_drops = 0; m_rd_data = '0; m_rd_bt = 0;
      m_rd_sob = 0; m_rd_vld = 0; m_ovf = 0; m_skp = 0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      sob  = (bus.symbols_count == 0);
      aa   = (bus.rx_data == 8'hAA);
      drop = bus.wr_en && m_in_skp && !sob && aa && bus.skp_drop_en && (m_drops < MD);
      m_rd_vld = 0;
      if (bus.rd_en && !was_empty) begin
        e = mq.pop_front();
        m_rd_vld  = 1;
        m_rd_data = e[DW-1:0];
        m_rd_sob  = e[DW];
        m_rd_bt   = e[DW+1];
      end
      if (bus.wr_en && !drop) begin
        if (was_full) m_ovf = 1;
        else mq.push_back({bus.block_type, sob, bus.rx_data});
      end
      m_skp = drop;
      if (bus.wr_en) begin
        if (sob) begin
          m_in_skp = bus.block_type && aa;
          m_drops  = 0;
        end else if (m_in_skp) begin
          if (drop) m_drops++;
          else if (!aa) m_in_skp = 0;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rx_clk) begin
    if (cmp_en) begin
      chk("m.rd_valid",    32'(bus.rd_valid),      32'(m_rd_vld));
      chk("m.rd_data",     32'(bus.rd_data),       32'(m_rd_data));
      chk("m.rd_blk_type", 32'(bus.rd_block_type), 32'(m_rd_bt));
      chk("m.rd_sob",      32'(bus.rd_sob),        32'(m_rd_sob));
      chk("m.occupancy",   32'(bus.occupancy),     32'(mq.size()));
      chk("m.empty",       32'(bus.empty),         32'(mq.size() == 0));
      chk("m.full",        32'(bus.full),          32'(mq.size() == DEPTH));
      chk("m.overflow",    32'(bus.overflow),      32'(m_ovf));
      chk("m.skp_dropped", 32'(bus.skp_dropped),   32'(m_skp));
    end
  end

  task automatic drive(bit wr, logic [DW-1:0] d, bit bt, logic [SCW-1:0] sc, bit de, bit rd);
    bus.wr_en = wr; bus.rx_data = d; bus.block_type = bt;
    bus.symbols_count = sc; bus.skp_drop_en = de; bus.rd_en = rd;
    @(posedge rx_clk); #1;
  endtask

  task automatic idle();
    drive(0, 8'h00, 0, 4'h0, 0, 0);
  endtask

  task automatic soft_clear();
    soft_rst = 1'b1;
    idle();
    soft_rst = 1'b0;
  endtask

  initial begin
    int pulses;
    logic [DW-1:0] skp_exp [5];
    skp_exp[0] = 8'hAA; skp_exp[1] = 8'hAA; skp_exp[2] = 8'hAA;
    skp_exp[3] = 8'hAA; skp_exp[4] = 8'hE1;
    bus.wr_en = 0; bus.rx_data = '0; bus.block_type = 0;
    bus.symbols_count = '0; bus.skp_drop_en = 0; bus.rd_en = 0;
    cmp_en = 1'b1;
    repeat (3) @(posedge rx_clk);
    #1;
    chk("rst.empty",     32'(bus.empty),     32'd1);
    chk("rst.full",      32'(bus.full),      32'd0);
    chk("rst.occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst.rd_valid",  32'(bus.rd_valid),  32'd0);
    #2 rx_rst = 1'b0;

    // Fill to full, then one write too many.
    for (int i = 0; i < 16; i++) drive(1, 8'(i), 0, 4'(i), 0, 0);
    chk("fill.full",      32'(bus.full),      32'd1);
    chk("fill.occupancy", 32'(bus.occupancy), 32'd16);
    chk("fill.overflow",  32'(bus.overflow),  32'd0);
    drive(1, 8'h10, 0, 4'h0, 0, 0);
    chk("ovf.overflow",   32'(bus.overflow),  32'd1);
    chk("ovf.occupancy",  32'(bus.occupancy), 32'd16);

    // Full: read and write together, write refused.
    drive(1, 8'h11, 0, 4'h1, 0, 1);
    chk("fullrw.occupancy", 32'(bus.occupancy), 32'd15);
    chk("fullrw.rd_valid",  32'(bus.rd_valid),  32'd1);
    chk("fullrw.rd_data",   32'(bus.rd_data),   32'h00);
    chk("fullrw.rd_sob",    32'(bus.rd_sob),    32'd1);
    for (int i = 1; i < 16; i++) drive(0, 8'h00, 0, 4'h0, 0, 1);
    chk("drain.rd_data", 32'(bus.rd_data), 32'h0F);
    chk("drain.rd_sob",  32'(bus.rd_sob),  32'd0);
    chk("drain.empty",   32'(bus.empty),   32'd1);
    idle();
    chk("hold.rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("hold.rd_data",  32'(bus.rd_data),  32'h0F);

    // Empty: simultaneous write and read, read ignored.
    drive(1, 8'h5A, 0, 4'h0, 0, 1);
    chk("emptyrw.occupancy", 32'(bus.occupancy), 32'd1);
    chk("emptyrw.rd_valid",  32'(bus.rd_valid),  32'd0);
    drive(0, 8'h00, 0, 4'h0, 0, 1);
    chk("emptyrw.rd_data",   32'(bus.rd_data),   32'h5A);
    chk("emptyrw.rd_valid2", 32'(bus.rd_valid),  32'd1);
    idle();
    soft_clear();
    chk("soft.overflow", 32'(bus.overflow), 32'd0);
    chk("soft.rd_data",  32'(bus.rd_data),  32'h00);

    // SKP ordered set with deletion enabled.
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1, (i == 8) ? 8'hE1 : 8'hAA, 1, 4'(i), 1, 0);
      if (bus.skp_dropped) pulses++;
    end
    idle();
    chk("skp.pulses",    32'(pulses),        32'd4);
    chk("skp.occupancy", 32'(bus.occupancy), 32'd5);
    for (int k = 0; k < 5; k++) begin
      drive(0, 8'h00, 0, 4'h0, 0, 1);
      chk("skp.rd_data", 32'(bus.rd_data),       32'(skp_exp[k]));
      chk("skp.rd_bt",   32'(bus.rd_block_type), 32'd1);
    end
    idle();

    // Same set with deletion disabled.
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1, (i == 8) ? 8'hE1 : 8'hAA, 1, 4'(i), 0, 0);
      if (bus.skp_dropped) pulses++;
    end
    idle();
    chk("noskp.pulses",    32'(pulses),        32'd0);
    chk("noskp.occupancy", 32'(bus.occupancy), 32'd9);
    for (int k = 0; k < 9; k++) drive(0, 8'h00, 0, 4'h0, 0, 1);
    idle();

    // A new block start aborts a pending SKP block.
    drive(1, 8'hAA, 1, 4'h0, 1, 0);
    drive(1, 8'h55, 0, 4'h0, 1, 0);
    drive(1, 8'hAA, 0, 4'h1, 1, 0);
    chk("abort.skp_dropped", 32'(bus.skp_dropped), 32'd0);
    chk("abort.occupancy",   32'(bus.occupancy),   32'd3);
    idle();
    soft_clear();

    // Dropped symbol while full must not raise overflow.
    for (int i = 0; i < 15; i++) drive(1, 8'(8'h20 + i), 0, 4'(i), 0, 0);
    drive(1, 8'hAA, 1, 4'h0, 1, 0);
    drive(1, 8'hAA, 1, 4'h1, 1, 0);
    chk("fulldrop.skp_dropped", 32'(bus.skp_dropped), 32'd1);
    chk("fulldrop.overflow",    32'(bus.overflow),    32'd0);
    chk("fulldrop.occupancy",   32'(bus.occupancy),   32'd16);
    drive(1, 8'hE1, 1, 4'h2, 1, 0);
    chk("fullend.overflow", 32'(bus.overflow), 32'd1);
    idle();
    soft_clear();

    // Async reset mid-operation with 7 entries and overflow set.
    for (int i = 0; i < 17; i++) drive(1, 8'(8'h40 + i), 0, 4'(i), 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 8'h00, 0, 4'h0, 0, 1);
    chk("prerst.occupancy", 32'(bus.occupancy), 32'd7);
    chk("prerst.overflow",  32'(bus.overflow),  32'd1);
    bus.rd_en = 0;
    #2 rx_rst = 1'b1;
    #1;
    chk("arst.occupancy", 32'(bus.occupancy),     32'd0);
    chk("arst.overflow",  32'(bus.overflow),      32'd0);
    chk("arst.empty",     32'(bus.empty),         32'd1);
    chk("arst.full",      32'(bus.full),          32'd0);
    chk("arst.rd_valid",  32'(bus.rd_valid),      32'd0);
    chk("arst.rd_data",   32'(bus.rd_data),       32'h00);
    chk("arst.rd_sob",    32'(bus.rd_sob),        32'd0);
    chk("arst.rd_bt",     32'(bus.rd_block_type), 32'd0);
    @(posedge rx_clk);
    #3 rx_rst = 1'b0;
    drive(1, 8'h33, 0, 4'h0, 0, 0);
    chk("post.occupancy", 32'(bus.occupancy), 32'd1);
    drive(0, 8'h00, 0, 4'h0, 0, 1);
    chk("post.rd_data",  32'(bus.rd_data),  32'h33);
    chk("post.rd_valid", 32'(bus.rd_valid), 32'd1);
    idle();
    idle();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
